// File: rtl/avr_button_port_if.sv
// I/O bus between the AVR core and the button port.
// The core drives address, strobes and write data; the port returns read data and its interrupt request.
interface avr_button_port_if;
   logic [5:0] io_addr;
   logic       io_re;
   logic       io_we;
   logic [7:0] io_di;
   logic [7:0] io_do;
   logic       irq;

   modport master (
      output io_addr, io_re, io_we, io_di,
      input  io_do, irq
   );

   modport slave (
      input  io_addr, io_re, io_we, io_di,
      output io_do, irq
   );
endinterface

// File: rtl/avr_button_port.sv
// Button input peripheral: synchronizes and debounces five push-buttons and
// exposes level, press-event and interrupt-enable registers on the AVR I/O bus.
module avr_button_port #(
   parameter logic [5:0]  BASE_ADDR       = 6'h10,
   parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       buttons,
   avr_button_port_if.slave bus
);

   typedef enum logic [1:0] {
      REG_PIN = 2'd0,
      REG_EVT = 2'd1,
      REG_IEN = 2'd2
   } reg_sel_e;

   localparam logic [15:0] CNT_MAX = DEBOUNCE_CYCLES - 16'd1;

   logic [4:0]  s1;
   logic [4:0]  s2;
   logic [4:0]  pin;
   logic [4:0]  pin_nxt;
   logic [4:0]  evt;
   logic [4:0]  evt_nxt;
   logic [4:0]  ien;
   logic [15:0] cnt     [5];
   logic [15:0] cnt_nxt [5];

   logic [6:0]  offset;
   logic        hit;
   reg_sel_e    sel;
   logic        wr_evt;
   logic        wr_ien;
   logic [4:0]  clr_mask;
   logic [7:0]  rdata;
   logic        unused_bits;

   // Debounce: a change is accepted only after CNT_MAX+1 consecutive disagreeing samples.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no latch is inferred.
      pin_nxt = pin;
      for (int i = 0; i < 5; i++) begin
         cnt_nxt[i] = cnt[i];
         if (s2[i] == pin[i]) begin
            cnt_nxt[i] = '0;
         end else if (cnt[i] == CNT_MAX) begin
            cnt_nxt[i] = '0;
            pin_nxt[i] = s2[i];
         end else begin
            cnt_nxt[i] = cnt[i] + 16'd1;
         end
      end
   end

   // The extra top bit of the subtraction flags addresses below BASE_ADDR.
   assign offset = {1'b0, bus.io_addr} - {1'b0, BASE_ADDR};
   assign hit    = ~offset[6] && (offset[5:0] < 6'd3);
   assign sel    = reg_sel_e'(offset[1:0]);
   assign wr_evt = bus.io_we && hit && (sel == REG_EVT);
   assign wr_ien = bus.io_we && hit && (sel == REG_IEN);

   // Press detection ORs in after the clear, so a same-edge set wins.
   assign clr_mask = wr_evt ? bus.io_di[4:0] : 5'b0;
   assign evt_nxt  = (evt & ~clr_mask) | (pin_nxt & ~pin);

   always_comb begin
      rdata = 8'h00;
      if (bus.io_re && hit) begin
         case (sel)
            REG_PIN: rdata = {3'b000, pin};
            REG_EVT: rdata = {3'b000, evt};
            REG_IEN: rdata = {3'b000, ien};
            default: rdata = 8'h00;
         endcase
      end
   end

   assign bus.io_do  = rdata;
   assign bus.irq    = |(evt & ien);
   assign unused_bits = ^bus.io_di[7:5];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1  <= '0;
         s2  <= '0;
         pin <= '0;
         evt <= '0;
         ien <= '0;
         // NOTE: the counter array is architectural state, so each entry is reset, not left as an unreset memory.
         for (int i = 0; i < 5; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
         s1  <= buttons;
         s2  <= s1;
         pin <= pin_nxt;
         evt <= evt_nxt;
         for (int i = 0; i < 5; i++) begin
            cnt[i] <= cnt_nxt[i];
         end
         if (wr_ien) begin
            ien <= bus.io_di[4:0];
         end
      end
   end

endmodule

// File: tb/tb_avr_button_port.sv
// Directed bench for avr_button_port with DEBOUNCE_CYCLES=4; expected values go
// through a scoreboard queue and are compared with immediate assertions.
module tb_avr_button_port;

   localparam logic [5:0] BASE  = 6'h10;
   localparam logic [5:0] PIN_A = BASE;
   localparam logic [5:0] EVT_A = BASE + 6'd1;
   localparam logic [5:0] IEN_A = BASE + 6'd2;
   localparam logic [5:0] OOR_A = BASE + 6'd3;

   logic       clk;
   logic       rst;
   logic [4:0] buttons;

   int checks   = 0;
   int failures = 0;

   logic [7:0] exp_q[$];
   string      tag_q[$];

   avr_button_port_if io ();

   avr_button_port #(
      .BASE_ADDR       (BASE),
      .DEBOUNCE_CYCLES (16'd4)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .buttons (buttons),
      .bus     (io)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic expect_val(input logic [7:0] exp, input string tag);
      exp_q.push_back(exp);
      tag_q.push_back(tag);
   endtask

   task automatic check_out(input logic [7:0] obs);
      logic [7:0] exp;
      string      tag;
      exp = exp_q.pop_front();
      tag = tag_q.pop_front();
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic read_reg(input logic [5:0] a, input logic [7:0] exp, input string tag);
      @(negedge clk);
      io.io_addr = a;
      io.io_re   = 1'b1;
      expect_val(exp, tag);
      #1;
      check_out(io.io_do);
      io.io_re = 1'b0;
   endtask

   task automatic check_irq(input logic exp, input string tag);
      @(negedge clk);
      expect_val({7'b0, exp}, tag);
      #1;
      check_out({7'b0, io.irq});
   endtask

   task automatic write_reg(input logic [5:0] a, input logic [7:0] d);
      @(negedge clk);
      io.io_addr = a;
      io.io_di   = d;
      io.io_we   = 1'b1;
      @(posedge clk);
      #1;
      io.io_we = 1'b0;
   endtask

   initial begin
      rst        = 1'b1;
      buttons    = 5'b11111;
      io.io_addr = '0;
      io.io_re   = 1'b0;
      io.io_we   = 1'b0;
      io.io_di   = '0;

      // Reset with all buttons held
      repeat (3) @(posedge clk);
      read_reg(PIN_A, 8'h00, "pin_in_reset");
      check_irq(1'b0, "irq_in_reset");
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk);
         read_reg(PIN_A, 8'h00, "pin_held_after_reset");
      end
      @(posedge clk);
      read_reg(PIN_A, 8'h1F, "pin_after_reset_debounce");
      read_reg(EVT_A, 8'h1F, "evt_after_reset_debounce");
      check_irq(1'b0, "irq_ien_zero");

      // Release all: no event on release
      @(negedge clk);
      buttons = 5'b00000;
      repeat (8) @(posedge clk);
      read_reg(PIN_A, 8'h00, "pin_all_released");
      read_reg(EVT_A, 8'h1F, "evt_no_release_event");
      write_reg(EVT_A, 8'h1F);
      read_reg(EVT_A, 8'h00, "evt_cleared");

      // Glitch of 3 cycles on button 0
      @(negedge clk);
      buttons = 5'b00001;
      repeat (3) @(posedge clk);
      @(negedge clk);
      buttons = 5'b00000;
      repeat (10) @(posedge clk);
      read_reg(PIN_A, 8'h00, "pin_glitch");
      read_reg(EVT_A, 8'h00, "evt_glitch");

      // Clean press of button 2: PIN updates on edge N+5
      @(negedge clk);
      buttons = 5'b00100;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk);
         read_reg(PIN_A, 8'h00, "pin_before_latency");
      end
      @(posedge clk);
      read_reg(PIN_A, 8'h04, "pin_at_latency");
      read_reg(EVT_A, 8'h04, "evt_press2");
      write_reg(EVT_A, 8'h04);
      read_reg(EVT_A, 8'h00, "evt_press2_cleared");

      // Interrupt and clear
      write_reg(IEN_A, 8'h1F);
      read_reg(IEN_A, 8'h1F, "ien_readback");
      check_irq(1'b0, "irq_no_events");
      @(negedge clk);
      buttons = 5'b01110;
      repeat (7) @(posedge clk);
      check_irq(1'b1, "irq_press_1_3");
      read_reg(EVT_A, 8'h0A, "evt_press_1_3");
      read_reg(PIN_A, 8'h0E, "pin_press_1_3");
      write_reg(EVT_A, 8'h02);
      read_reg(EVT_A, 8'h08, "evt_clear_bit1");
      check_irq(1'b1, "irq_bit3_pending");
      write_reg(EVT_A, 8'h08);
      check_irq(1'b0, "irq_all_cleared");
      read_reg(EVT_A, 8'h00, "evt_all_cleared");

      // Set/clear collision on button 0
      @(negedge clk);
      buttons = 5'b00000;
      repeat (8) @(posedge clk);
      read_reg(PIN_A, 8'h00, "pin_before_collision");
      @(negedge clk);
      buttons = 5'b00001;
      repeat (5) @(posedge clk);
      write_reg(EVT_A, 8'h01);
      read_reg(PIN_A, 8'h01, "pin_collision");
      read_reg(EVT_A, 8'h01, "evt_set_wins");
      check_irq(1'b1, "irq_collision");

      // Decode: out of range, strobe low, read-only PIN, reserved bits
      read_reg(OOR_A, 8'h00, "read_out_of_range");
      @(negedge clk);
      io.io_addr = PIN_A;
      expect_val(8'h00, "no_read_strobe");
      #1;
      check_out(io.io_do);
      write_reg(PIN_A, 8'h00);
      read_reg(PIN_A, 8'h01, "pin_write_ignored");
      write_reg(OOR_A, 8'h00);
      read_reg(IEN_A, 8'h1F, "ien_oor_write_ignored");
      write_reg(IEN_A, 8'hF5);
      read_reg(IEN_A, 8'h15, "ien_reserved_bits");
      write_reg(IEN_A, 8'h1F);

      // Release of held button 0
      @(negedge clk);
      buttons = 5'b00000;
      repeat (8) @(posedge clk);
      read_reg(PIN_A, 8'h00, "pin_released");
      read_reg(EVT_A, 8'h01, "evt_release_no_new");
      write_reg(EVT_A, 8'h1F);
      read_reg(EVT_A, 8'h00, "evt_final_clear");

      // Simultaneous read and write returns the pre-write value
      @(negedge clk);
      io.io_addr = IEN_A;
      io.io_di   = 8'h00;
      io.io_re   = 1'b1;
      io.io_we   = 1'b1;
      expect_val(8'h1F, "read_during_write");
      #1;
      check_out(io.io_do);
      @(posedge clk);
      #1;
      io.io_re = 1'b0;
      io.io_we = 1'b0;
      read_reg(IEN_A, 8'h00, "ien_after_rw");

      // Reset with a pending event and a held button
      write_reg(IEN_A, 8'h1F);
      @(negedge clk);
      buttons = 5'b10000;
      repeat (7) @(posedge clk);
      read_reg(EVT_A, 8'h10, "evt_before_reset");
      check_irq(1'b1, "irq_before_reset");
      @(negedge clk);
      rst = 1'b1;
      read_reg(EVT_A, 8'h00, "evt_in_reset");
      check_irq(1'b0, "irq_in_midreset");
      @(negedge clk);
      rst = 1'b0;
      read_reg(IEN_A, 8'h00, "ien_after_reset");
      repeat (3) @(posedge clk);
      read_reg(PIN_A, 8'h00, "pin_held_through_reset");
      repeat (4) @(posedge clk);
      read_reg(PIN_A, 8'h10, "pin_held_after_delay");
      read_reg(EVT_A, 8'h10, "evt_held_after_delay");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
